// File: rtl/rf_agu_pkg.sv
// Shared defaults and address-width helper for the AGU pointer register file.
package rf_agu_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_BYPASS = 1;

    // ceil(log2(depth)), never below 1 so a port always has at least one bit
    function automatic int aw_of(input int depth);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) >= depth) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/rf_agu_fwd.sv
// One read port: indexed lookup, out-of-range zeroing, write forwarding and stall term.
module rf_agu_fwd
    import rf_agu_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int BYPASS = DEF_BYPASS,
    localparam int AW    = aw_of(DEPTH)
) (
    input  logic [DEPTH*WIDTH-1:0] i_rf,
    input  logic [DEPTH-1:0]       i_busy,
    input  logic [AW-1:0]          i_raddr,
    input  logic                   i_we1,
    input  logic [AW-1:0]          i_waddr1,
    input  logic [WIDTH-1:0]       i_wdata1,
    input  logic                   i_we2,
    input  logic [AW-1:0]          i_waddr2,
    input  logic [WIDTH-1:0]       i_wdata2,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_stall
);

    logic w_hit1, w_hit2;

    // write enables arrive already qualified by range and reset
    assign w_hit1 = i_we1 && (i_waddr1 == i_raddr);
    assign w_hit2 = i_we2 && (i_waddr2 == i_raddr);

    always_comb begin
        o_data  = '0;
        o_stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_raddr == AW'(i)) begin
                o_data  = i_rf[i*WIDTH +: WIDTH];
                o_stall = i_busy[i];
            end
        end
        if ((BYPASS != 0) && (w_hit1 || w_hit2)) begin
            o_data  = w_hit2 ? i_wdata2 : i_wdata1;
            o_stall = 1'b0;
        end
    end

endmodule

// File: rtl/rf_agu_ptr.sv
// Pointer register file: two write ports, three read ports, per-register load lock.
module rf_agu_ptr
    import rf_agu_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int BYPASS = DEF_BYPASS,
    localparam int AW    = aw_of(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic [AW-1:0]    i_waddr1,
    input  logic [AW-1:0]    i_waddr2,
    input  logic             i_write1,
    input  logic             i_write2,
    input  logic [AW-1:0]    i_raddr1,
    input  logic [AW-1:0]    i_raddr2,
    input  logic [AW-1:0]    i_raddr3,
    output logic [WIDTH-1:0] o_out1,
    output logic [WIDTH-1:0] o_out2,
    output logic [WIDTH-1:0] o_out3,
    input  logic             i_lock_req,
    input  logic [AW-1:0]    i_lock_addr,
    output logic             o_stall1,
    output logic             o_stall2,
    output logic             o_stall3,
    output logic             o_collide
);

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [DEPTH-1:0][WIDTH-1:0] r_rf;
    logic [DEPTH-1:0]            r_busy;
    logic                        r_collide;
    logic                        w_we1, w_we2, w_lock;

    // gating with reset keeps the forwarding path quiet while held in reset
    assign w_we1  = i_write1   && i_rst_n && ({1'b0, i_waddr1}    < DEPTH_C);
    assign w_we2  = i_write2   && i_rst_n && ({1'b0, i_waddr2}    < DEPTH_C);
    assign w_lock = i_lock_req && i_rst_n && ({1'b0, i_lock_addr} < DEPTH_C);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rf      <= '0;
            r_busy    <= '0;
            r_collide <= 1'b0;
        end else begin
            // later assignments win: port 2 over port 1, lock over write-clear
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we1 && (i_waddr1 == AW'(i))) begin
                    r_rf[i]   <= i_in1;
                    r_busy[i] <= 1'b0;
                end
                if (w_we2 && (i_waddr2 == AW'(i))) begin
                    r_rf[i]   <= i_in2;
                    r_busy[i] <= 1'b0;
                end
                if (w_lock && (i_lock_addr == AW'(i))) r_busy[i] <= 1'b1;
            end
            r_collide <= w_we1 && w_we2 && (i_waddr1 == i_waddr2);
        end
    end

    assign o_collide = r_collide;

    rf_agu_fwd #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS)) u_rd [2:0] (
        .i_rf     (r_rf),
        .i_busy   (r_busy),
        .i_raddr  ({i_raddr3, i_raddr2, i_raddr1}),
        .i_we1    (w_we1),
        .i_waddr1 (i_waddr1),
        .i_wdata1 (i_in1),
        .i_we2    (w_we2),
        .i_waddr2 (i_waddr2),
        .i_wdata2 (i_in2),
        .o_data   ({o_out3, o_out2, o_out1}),
        .o_stall  ({o_stall3, o_stall2, o_stall1})
    );

endmodule

// File: tb/tb_rf_agu_ptr.sv
// Directed bench: forwarding and non-forwarding 4-entry files plus a 6-entry file.
module tb_rf_agu_ptr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in1, in2;
    logic [1:0]  waddr1, waddr2, raddr1, raddr2, raddr3, lock_addr;
    logic        write1, write2, lock_req;
    logic [15:0] a_out1, a_out2, a_out3, b_out1, b_out2, b_out3;
    logic        a_st1, a_st2, a_st3, a_col, b_st1, b_st2, b_st3, b_col;

    logic [15:0] d_in1, d_in2;
    logic [2:0]  d_waddr1, d_waddr2, d_raddr1, d_raddr2, d_raddr3, d_lock_addr;
    logic        d_write1, d_write2, d_lock_req;
    logic [15:0] d_out1, d_out2, d_out3;
    logic        d_st1, d_st2, d_st3, d_col;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_agu_ptr #(.WIDTH(16), .DEPTH(4), .BYPASS(1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_in1(in1), .i_in2(in2),
        .i_waddr1(waddr1), .i_waddr2(waddr2), .i_write1(write1), .i_write2(write2),
        .i_raddr1(raddr1), .i_raddr2(raddr2), .i_raddr3(raddr3),
        .o_out1(a_out1), .o_out2(a_out2), .o_out3(a_out3),
        .i_lock_req(lock_req), .i_lock_addr(lock_addr),
        .o_stall1(a_st1), .o_stall2(a_st2), .o_stall3(a_st3), .o_collide(a_col));

    rf_agu_ptr #(.WIDTH(16), .DEPTH(4), .BYPASS(0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_in1(in1), .i_in2(in2),
        .i_waddr1(waddr1), .i_waddr2(waddr2), .i_write1(write1), .i_write2(write2),
        .i_raddr1(raddr1), .i_raddr2(raddr2), .i_raddr3(raddr3),
        .o_out1(b_out1), .o_out2(b_out2), .o_out3(b_out3),
        .i_lock_req(lock_req), .i_lock_addr(lock_addr),
        .o_stall1(b_st1), .o_stall2(b_st2), .o_stall3(b_st3), .o_collide(b_col));

    rf_agu_ptr #(.WIDTH(16), .DEPTH(6), .BYPASS(1)) u_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_in1(d_in1), .i_in2(d_in2),
        .i_waddr1(d_waddr1), .i_waddr2(d_waddr2), .i_write1(d_write1), .i_write2(d_write2),
        .i_raddr1(d_raddr1), .i_raddr2(d_raddr2), .i_raddr3(d_raddr3),
        .o_out1(d_out1), .o_out2(d_out2), .o_out3(d_out3),
        .i_lock_req(d_lock_req), .i_lock_addr(d_lock_addr),
        .o_stall1(d_st1), .o_stall2(d_st2), .o_stall3(d_st3), .o_collide(d_col));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in1 = '0; in2 = '0; waddr1 = '0; waddr2 = '0; raddr1 = '0; raddr2 = '0; raddr3 = '0;
        write1 = 1'b0; write2 = 1'b0; lock_req = 1'b0; lock_addr = '0;
        d_in1 = '0; d_in2 = '0; d_waddr1 = '0; d_waddr2 = '0; d_raddr1 = '0; d_raddr2 = '0;
        d_raddr3 = '0; d_write1 = 1'b0; d_write2 = 1'b0; d_lock_req = 1'b0; d_lock_addr = '0;
        #3;
        chk("rst_out", {a_out1, a_out2}, 32'h0);
        chk("rst_stall_col", {a_st1, a_st2, a_st3, a_col, b_col}, 32'h0);

        // write and lock attempted while reset is held: must be ignored
        write1 = 1'b1; waddr1 = 2'd2; in1 = 16'hBEEF; raddr1 = 2'd2;
        lock_req = 1'b1; lock_addr = 2'd2;
        #1 chk("rst_nobypass", a_out1, 32'h0);
        tick();
        chk("rst_nowrite", b_out1, 32'h0);
        chk("rst_nolock", b_st1, 32'h0);
        rst_n = 1'b1; lock_req = 1'b0; write1 = 1'b0;

        // basic write then read
        write1 = 1'b1; waddr1 = 2'd2; in1 = 16'h1234; raddr1 = 2'd2; raddr2 = 2'd3;
        #1 chk("byp_w1", a_out1, 32'h1234);
        chk("nobyp_w1", b_out1, 32'h0);
        tick(); write1 = 1'b0;
        #1 chk("rd_r2", {a_out1, b_out1}, 32'h1234_1234);
        chk("rd_r3", a_out2, 32'h0);

        // collision: port 2 wins, collide pulses one cycle
        write1 = 1'b1; waddr1 = 2'd1; in1 = 16'hAAAA;
        write2 = 1'b1; waddr2 = 2'd1; in2 = 16'h5555; raddr1 = 2'd1;
        #1 chk("byp_col_prio", a_out1, 32'h5555);
        chk("nobyp_col_old", b_out1, 32'h0);
        chk("col_pre", a_col, 32'h0);
        tick(); write1 = 1'b0; write2 = 1'b0;
        #1 chk("col_data", {a_out1, b_out1}, 32'h5555_5555);
        chk("col_set", {a_col, b_col}, 32'h3);
        tick();
        chk("col_clr", {a_col, b_col}, 32'h0);

        // forwarding on read port 3
        write2 = 1'b1; waddr2 = 2'd3; in2 = 16'h0F0F; raddr3 = 2'd3;
        #1 chk("byp_out3", a_out3, 32'h0F0F);
        chk("nobyp_out3_old", b_out3, 32'h0);
        tick(); write2 = 1'b0;
        #1 chk("nobyp_out3_new", b_out3, 32'h0F0F);

        // lock then clearing write
        lock_req = 1'b1; lock_addr = 2'd0; raddr1 = 2'd0;
        #1 chk("lock_pre", a_st1, 32'h0);
        tick(); lock_req = 1'b0;
        #1 chk("lock_stall", {a_st1, b_st1}, 32'h3);
        write1 = 1'b1; waddr1 = 2'd0; in1 = 16'h0042;
        #1 chk("lock_byp_stall", {a_st1, a_out1}, {15'h0, 1'b0, 16'h0042});
        chk("lock_nobyp_stall", {b_st1, b_out1}, {15'h0, 1'b1, 16'h0000});
        tick(); write1 = 1'b0;
        #1 chk("lock_cleared", {a_st1, b_st1}, 32'h0);
        chk("lock_data", b_out1, 32'h0042);

        // lock and write to the same register: data lands, lock wins
        lock_req = 1'b1; lock_addr = 2'd1; write1 = 1'b1; waddr1 = 2'd1; in1 = 16'h7777;
        raddr2 = 2'd1;
        tick(); lock_req = 1'b0; write1 = 1'b0;
        #1 chk("lockwr_data", {a_out2, b_out2}, 32'h7777_7777);
        chk("lockwr_stall", {a_st2, b_st2}, 32'h3);

        // two writes and a lock to three distinct registers
        write1 = 1'b1; waddr1 = 2'd2; in1 = 16'h1111;
        write2 = 1'b1; waddr2 = 2'd3; in2 = 16'h2222;
        lock_req = 1'b1; lock_addr = 2'd0;
        raddr1 = 2'd2; raddr2 = 2'd3; raddr3 = 2'd0;
        tick(); write1 = 1'b0; write2 = 1'b0;
        #1 chk("tri_data", {b_out1, b_out2}, 32'h1111_2222);
        chk("tri_stall", {a_st3, b_st3, a_st1, a_st2, a_col}, 32'h18);
        tick(); lock_req = 1'b0;
        chk("relock_busy", {a_st3, b_st3}, 32'h3);

        // 6-entry file: out-of-range reads and writes
        d_write1 = 1'b1; d_waddr1 = 3'd5; d_in1 = 16'hABCD; d_raddr1 = 3'd5;
        tick(); d_write1 = 1'b0;
        #1 chk("d6_r5", d_out1, 32'hABCD);
        d_raddr2 = 3'd7;
        #1 chk("d6_rd7", d_out2, 32'h0);
        d_write1 = 1'b1; d_waddr1 = 3'd6; d_in1 = 16'hFFFF; d_raddr3 = 3'd6;
        d_lock_req = 1'b1; d_lock_addr = 3'd7;
        #1 chk("d6_rd6_wr6", {d_out3, 15'h0, d_st3}, 32'h0);
        tick(); d_write1 = 1'b0; d_lock_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d_raddr2 = 3'(i);
            #1 chk($sformatf("d6_keep_r%0d", i), {d_out2, 15'h0, d_st2}, 32'h0);
        end
        chk("d6_keep_r5", d_out1, 32'hABCD);
        d_raddr2 = 3'd6; d_raddr3 = 3'd7;
        #1 chk("d6_oor", {d_out2, d_out3}, 32'h0);
        chk("d6_oor_stall", {d_st2, d_st3, d_col}, 32'h0);

        // asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1 chk("arst_a", {a_out1, a_out2}, 32'h0);
        chk("arst_stall", {a_st1, a_st2, a_st3, b_st3, a_col}, 32'h0);
        chk("arst_d", d_out1, 32'h0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_data", {b_out1, d_out1}, 32'h0);
        chk("post_rst_lock", {a_st3, b_st3, a_st2}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
